// File: rtl/lc3_bus_checker.sv
// lc3_bus_checker: lockstep checker pairing and comparing the memory-write streams of two LC-3 cores.
// Optional idle-partner timeout check is enabled by defining LC3_CHK_TIMEOUT_EN.
module lc3_bus_checker #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwe_0,
  input  logic [15:0] mar_0,
  input  logic [15:0] mdr_0,
  input  logic        memwe_1,
  input  logic [15:0] mar_1,
  input  logic [15:0] mdr_1,
  output logic        fail,
  output logic [1:0]  fail_code,
  output logic [15:0] fail_addr_0,
  output logic [15:0] fail_addr_1,
  output logic [15:0] fail_data_0,
  output logic [15:0] fail_data_1,
  output logic [15:0] match_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {S_RUN, S_FAIL} state_t;
  state_t state_q, state_d;
  logic [31:0] mem_q [2][DEPTH];
  logic [1:0][AW:0] wp_q, rp_q;
  logic [1:0][31:0] wdata, head, fent_q, fent_d;
  logic [1:0] we, empty, full, ovf, push;
  logic [1:0] code_q, code_d;
  logic [15:0] match_q;
  logic run, pop, mism, tmo;
  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("lc3_bus_checker: illegal DEPTH or TIMEOUT");
  end
  assign we    = {memwe_1, memwe_0};
  assign wdata = {{mar_1, mdr_1}, {mar_0, mdr_0}};
  assign run   = state_q == S_RUN;
  assign pop   = run && !empty[0] && !empty[1];
  assign mism  = pop && head[0] != head[1];
  for (genvar c = 0; c < 2; c++) begin : g_fifo
    assign empty[c] = wp_q[c] == rp_q[c];
    assign full[c]  = wp_q[c] == {~rp_q[c][AW], rp_q[c][AW-1:0]};
    assign head[c]  = mem_q[c][rp_q[c][AW-1:0]];
    // a same-cycle pop frees a slot, so a push to a full FIFO is still accepted
    assign ovf[c]   = run && we[c] && full[c] && !pop;
    assign push[c]  = run && we[c] && (!full[c] || pop);
  end
`ifdef LC3_CHK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic waiting;
  assign waiting = run && (empty[0] != empty[1]);
  assign tmo     = waiting && tcnt_q == TW'(TIMEOUT - 1);
  assign tcnt_d  = waiting ? tcnt_q + 1'b1 : '0;
  always_ff @(posedge clk) tcnt_q <= reset ? '0 : tcnt_d;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    fent_d  = fent_q;
    if (mism) begin
      state_d = S_FAIL;
      code_d  = 2'd1;
      fent_d  = head;
    end else if (|ovf) begin
      state_d   = S_FAIL;
      code_d    = 2'd3;
      fent_d[0] = ovf[0] ? wdata[0] : '0;
      fent_d[1] = ovf[1] ? wdata[1] : '0;
    end else if (tmo) begin
      state_d   = S_FAIL;
      code_d    = 2'd2;
      fent_d[0] = empty[0] ? '0 : head[0];
      fent_d[1] = empty[1] ? '0 : head[1];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      code_q  <= '0;
      fent_q  <= '0;
      match_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      fent_q  <= fent_d;
      if (pop && !mism) match_q <= match_q + 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          mem_q[i][wp_q[i][AW-1:0]] <= wdata[i];
          wp_q[i] <= wp_q[i] + 1'b1;
        end
        if (pop) rp_q[i] <= rp_q[i] + 1'b1;
      end
    end
  end
  assign fail        = state_q == S_FAIL;
  assign fail_code   = code_q;
  assign {fail_addr_0, fail_data_0} = fent_q[0];
  assign {fail_addr_1, fail_data_1} = fent_q[1];
  assign match_count = match_q;
endmodule

// File: doc/lc3_bus_checker.md
LC3_BUS_CHECKER -- requirements
Module: lc3_bus_checker

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning per-core write-FIFO depth in entries (power of two, 2..64).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, meaning maximum cycles one FIFO may stay non-empty while the other stays empty.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port memwe_0  input  1  core 0 memory write enable.
REQ-006 The block SHALL have port mar_0  input  16  core 0 memory address.
REQ-007 The block SHALL have port mdr_0  input  16  core 0 write data.
REQ-008 The block SHALL have ports memwe_1, mar_1 and mdr_1, identical to REQ-005..007, for core 1.
REQ-009 The block SHALL have port fail  output  1  sticky failure flag.
REQ-010 The block SHALL have port fail_code  output  2  0 none, 1 mismatch, 2 timeout, 3 overflow.
REQ-011 The block SHALL have ports fail_addr_0 and fail_addr_1  output  16 each  addresses of the failing entries.
REQ-012 The block SHALL have ports fail_data_0 and fail_data_1  output  16 each  data of the failing entries.
REQ-013 The block SHALL have port match_count  output  16  number of matched write pairs.

Function
REQ-014 A write SHALL be captured when memwe_x=1 at a rising clk edge: {mar_x, mdr_x} is pushed into FIFO x.
REQ-015 The block SHALL implement two states: RUN and FAIL.
REQ-016 In RUN, when both FIFOs are non-empty, the block SHALL pop one entry from each in the same cycle and compare the 32-bit entries.
REQ-017 On equal entries, match_count SHALL increment by 1 on the same edge as the pop, wrapping 0xFFFF->0x0000.
REQ-018 On unequal entries, the block SHALL go to FAIL with fail_code=1 and latch both entries into fail_addr_x/fail_data_x on that edge, so fail is visible one cycle after the compare cycle.
REQ-019 A push to a full FIFO not popped in the same cycle SHALL be dropped and cause FAIL with fail_code=3; fail_addr_x/fail_data_x SHALL hold the dropped entry for the offending core and 0 for the other.
REQ-020 A push to a full FIFO that is popped in the same cycle SHALL be accepted, with no overflow.
REQ-021 In FAIL, the block SHALL perform no pops, compares or match_count updates; pushes are ignored and all fail outputs hold until reset.
REQ-022 When several failure causes occur in one cycle, priority SHALL be mismatch > overflow > timeout.
REQ-023 The FIFOs SHALL be first-word fall-through and the compare SHALL be combinational on FIFO heads, so a write pair pushed on edge N is compared at edge N+1.
REQ-024 Cores may be skewed arbitrarily within DEPTH entries, and ordering within each core SHALL be preserved.

Reset
REQ-025 reset=1 at a rising edge SHALL clear both FIFOs, the timeout counter and match_count, set state RUN, fail=0, fail_code=0 and all fail_addr_x/fail_data_x=0, regardless of state or in-flight entries.
REQ-026 Writes presented in a reset cycle SHALL NOT be captured.

Configuration
REQ-027 Macro LC3_CHK_TIMEOUT_EN SHALL control the timeout check.
REQ-028 With LC3_CHK_TIMEOUT_EN defined: a counter SHALL increment each RUN cycle where exactly one FIFO is non-empty and the other is empty, and clear otherwise; reaching TIMEOUT SHALL cause FAIL with fail_code=2 and latch the waiting FIFO's head entry for that core and 0 for the other.
REQ-029 Without LC3_CHK_TIMEOUT_EN: no counter SHALL exist and fail_code=2 SHALL never occur.

Verification
REQ-030 Both cores write (0x3000,0x1234) in the same cycle -> match_count=1 next cycle, fail=0.
REQ-031 Core 0 writes (0x3001,0xAAAA) at cycle 0 and core 1 writes it at cycle 5 -> match_count increments at cycle 6, fail=0.
REQ-032 Core 0 writes (0x3002,0x0001) and core 1 writes (0x3002,0x0002) -> fail=1, fail_code=1, fail_data_0=0x0001, fail_data_1=0x0002; later matching writes leave match_count unchanged.
REQ-033 DEPTH=8, core 0 makes 9 consecutive writes while core 1 is idle -> fail_code=3 on the 9th write, fail_addr_0 = 9th address.
REQ-034 With LC3_CHK_TIMEOUT_EN, TIMEOUT=64, core 1 writes once and core 0 stays idle -> fail_code=2 exactly 64 cycles after the entry becomes visible; without the macro -> fail stays 0.
REQ-035 Assert reset for 1 cycle while in FAIL with 3 entries queued -> all outputs 0 next cycle, and a new matched pair increments match_count to 1.
